// File: rtl/la_iopwrseq.sv
// la_iopwrseq
//   Power sequencer for one switchable io-ring supply segment. Drives the
//   ring control word (supply enable, isolation clamp, power-on-reset hold)
//   and supervises the ring's power-good feedback, latching timeouts and
//   brownouts as a fault.
//
// Ports
//   clk            sequencer clock
//   reset          synchronous, active-high reset
//   req            1 = segment should be powered, 0 = segment off
//   pgood          asynchronous power-good from the ring supply detector
//   timeout_cycles max wait for pgood to rise/fall (loaded on state entry)
//   settle_cycles  post-pgood settle time before release (loaded on entry)
//   ioring         control word: [0]=pwr_en, [1]=iso, [2]=por, rest 0
//   ready          segment powered and released
//   busy           transition in progress
//   fault          timeout or brownout latched
//   state          current FSM state code
module la_iopwrseq #(
    parameter int RINGW = 8,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             pgood,
    input  logic [CNTW-1:0]  timeout_cycles,
    input  logic [CNTW-1:0]  settle_cycles,
    output logic [RINGW-1:0] ioring,
    output logic             ready,
    output logic             busy,
    output logic             fault,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_PWRUP   = 3'd1,
        S_SETTLE  = 3'd2,
        S_ON      = 3'd3,
        S_ISOLATE = 3'd4,
        S_PWRDN   = 3'd5,
        S_FAULT   = 3'd6
    } state_t;

    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    state_t          r_state;
    state_t          w_nxt_state;
    logic [CNTW-1:0] r_cnt;
    logic [CNTW-1:0] w_nxt_cnt;
    logic            w_cnt_zero;
    logic            r_pg_m;
    logic            r_pg_s;
    logic            r_en;
    logic            r_iso;
    logic            r_por;
    logic            r_ready;
    logic            r_busy;
    logic            r_fault;

    assign w_cnt_zero = (r_cnt == '0);

    // Next-state / counter logic. The counter only decrements while nonzero,
    // so it saturates at 0 rather than wrapping.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        case (r_state)
            S_OFF: begin
                if (req) begin
                    w_nxt_state = S_PWRUP;
                    w_nxt_cnt   = timeout_cycles;
                end
            end
            S_PWRUP: begin
                if (!req) begin
                    w_nxt_state = S_PWRDN;
                    w_nxt_cnt   = timeout_cycles;
                end else if (r_pg_s) begin
                    w_nxt_state = S_SETTLE;
                    w_nxt_cnt   = settle_cycles;
                end else if (w_cnt_zero) begin
                    w_nxt_state = S_FAULT;
                end else begin
                    w_nxt_cnt = r_cnt - CNT_ONE;
                end
            end
            S_SETTLE: begin
                if (!req) begin
                    w_nxt_state = S_PWRDN;
                    w_nxt_cnt   = timeout_cycles;
                end else if (!r_pg_s) begin
                    w_nxt_state = S_FAULT;
                end else if (w_cnt_zero) begin
                    w_nxt_state = S_ON;
                end else begin
                    w_nxt_cnt = r_cnt - CNT_ONE;
                end
            end
            S_ON: begin
                // Brownout outranks a power-down request.
                if (!r_pg_s) begin
                    w_nxt_state = S_FAULT;
                end else if (!req) begin
                    w_nxt_state = S_ISOLATE;
                end
            end
            S_ISOLATE: begin
                // One cycle with clamps closed before the supply is dropped.
                w_nxt_state = S_PWRDN;
                w_nxt_cnt   = timeout_cycles;
            end
            S_PWRDN: begin
                // req is deliberately ignored: no re-arm mid power-down.
                if (!r_pg_s) begin
                    w_nxt_state = S_OFF;
                end else if (w_cnt_zero) begin
                    w_nxt_state = S_FAULT;
                end else begin
                    w_nxt_cnt = r_cnt - CNT_ONE;
                end
            end
            S_FAULT: begin
                if (!req) begin
                    w_nxt_state = S_OFF;
                end
            end
            default: begin
                w_nxt_state = S_OFF;
            end
        endcase
    end

    // State, counter, synchronizer and outputs. Outputs are decoded from the
    // next state so they change on the same edge as the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_OFF;
            r_cnt   <= '0;
            r_pg_m  <= 1'b0;
            r_pg_s  <= 1'b0;
            r_en    <= 1'b0;
            r_iso   <= 1'b1;
            r_por   <= 1'b1;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_pg_m  <= pgood;
            r_pg_s  <= r_pg_m;
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_en    <= (w_nxt_state inside {S_PWRUP, S_SETTLE, S_ON, S_ISOLATE});
            r_iso   <= (w_nxt_state != S_ON);
            r_por   <= (w_nxt_state != S_ON);
            r_ready <= (w_nxt_state == S_ON);
            r_busy  <= (w_nxt_state inside {S_PWRUP, S_SETTLE, S_ISOLATE, S_PWRDN});
            r_fault <= (w_nxt_state == S_FAULT);
        end
    end

    always_comb begin
        ioring      = '0;
        ioring[2:0] = {r_por, r_iso, r_en};
    end

    assign ready = r_ready;
    assign busy  = r_busy;
    assign fault = r_fault;
    assign state = r_state;

endmodule

// File: tb/tb_la_iopwrseq.sv
// Self-checking bench for la_iopwrseq: table of per-cycle vectors for the
// nominal power-up/down and timeout flows, plus hand-written sequences for
// brownout, abort during settle, reset mid power-up and settle_cycles=0.
module tb_la_iopwrseq;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        pgood;
    logic [15:0] timeout_cycles;
    logic [15:0] settle_cycles;
    logic [7:0]  ioring;
    logic        ready;
    logic        busy;
    logic        fault;
    logic [2:0]  state;

    int n_cmp = 0;
    int n_bad = 0;
    bit inv_en = 1'b0;

    always #5 clk = ~clk;

    la_iopwrseq #(
        .RINGW (8),
        .CNTW  (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .pgood          (pgood),
        .timeout_cycles (timeout_cycles),
        .settle_cycles  (settle_cycles),
        .ioring         (ioring),
        .ready          (ready),
        .busy           (busy),
        .fault          (fault),
        .state          (state)
    );

    typedef struct {
        logic        rst;
        logic        rq;
        logic        pg;
        logic [15:0] to;
        logic [15:0] st;
        logic [2:0]  e_state;
        logic [7:0]  e_io;
        logic        e_rdy;
        logic        e_bsy;
        logic        e_flt;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic rst, input logic rq, input logic pg,
                                input logic [15:0] to, input logic [15:0] st,
                                input logic [2:0] es, input logic [7:0] eio,
                                input logic er, input logic eb, input logic ef);
        vec_t v;
        v.rst = rst; v.rq = rq; v.pg = pg; v.to = to; v.st = st;
        v.e_state = es; v.e_io = eio; v.e_rdy = er; v.e_bsy = eb; v.e_flt = ef;
        vq.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] es, input logic [7:0] eio,
                           input logic er, input logic eb, input logic ef);
        chk({tag, ".state"}, 32'(state), 32'(es));
        chk({tag, ".ioring"}, 32'(ioring), 32'(eio));
        chk({tag, ".ready"}, 32'(ready), 32'(er));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".fault"}, 32'(fault), 32'(ef));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic rq, input logic pg,
                         input logic [15:0] to, input logic [15:0] st);
        reset = rst; req = rq; pgood = pg; timeout_cycles = to; settle_cycles = st;
    endtask

    // Output invariants, sampled away from the active edge.
    always @(negedge clk) begin
        if (inv_en) begin
            chk("inv_isopor", 32'((state == 3'd3) || (ioring[2:1] == 2'b11)), 32'd1);
            chk("inv_rdy_bsy", 32'(ready & busy), 32'd0);
            chk("inv_fault", 32'(fault & (ready | busy)), 32'd0);
            chk("inv_upper0", 32'(ioring[7:3]), 32'd0);
        end
    end

    initial begin
        drive(1'b1, 1'b0, 1'b0, 16'd10, 16'd3);

        // Nominal power-up (timeout=10, settle=3), pgood 4 cycles after pwr_en,
        // then power-down with pgood falling 3 cycles after pwr_en drops.
        add(1, 0, 0, 10, 3,  0, 8'h6, 0, 0, 0);
        add(0, 1, 0, 10, 3,  1, 8'h7, 0, 1, 0);
        for (int i = 0; i < 4; i++) add(0, 1, 0, 10, 3,  1, 8'h7, 0, 1, 0);
        for (int i = 0; i < 2; i++) add(0, 1, 1, 10, 3,  1, 8'h7, 0, 1, 0);
        add(0, 1, 1, 10, 3,  2, 8'h7, 0, 1, 0);
        // settle change after entry must not extend SETTLE
        for (int i = 0; i < 3; i++) add(0, 1, 1, 10, 50, 2, 8'h7, 0, 1, 0);
        for (int i = 0; i < 2; i++) add(0, 1, 1, 10, 3,  3, 8'h1, 1, 0, 0);
        add(0, 0, 1, 10, 3,  4, 8'h7, 0, 1, 0);
        add(0, 0, 1, 10, 3,  5, 8'h6, 0, 1, 0);
        add(0, 0, 1, 10, 3,  5, 8'h6, 0, 1, 0);
        add(0, 1, 1, 10, 3,  5, 8'h6, 0, 1, 0);   // req ignored in PWRDN
        add(0, 0, 0, 10, 3,  5, 8'h6, 0, 1, 0);
        add(0, 0, 0, 10, 3,  5, 8'h6, 0, 1, 0);
        add(0, 0, 0, 10, 3,  0, 8'h6, 0, 0, 0);

        // Timeout: timeout=5 latched on entry; later change to 100 ignored.
        add(1, 0, 0, 5, 3,   0, 8'h6, 0, 0, 0);
        add(0, 1, 0, 5, 3,   1, 8'h7, 0, 1, 0);
        for (int i = 0; i < 2; i++) add(0, 1, 0, 5, 3,   1, 8'h7, 0, 1, 0);
        for (int i = 0; i < 3; i++) add(0, 1, 0, 100, 3, 1, 8'h7, 0, 1, 0);
        add(0, 1, 0, 5, 3,   6, 8'h6, 0, 0, 1);
        add(0, 1, 0, 5, 3,   6, 8'h6, 0, 0, 1);
        add(0, 0, 0, 5, 3,   0, 8'h6, 0, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].rq, vq[i].pg, vq[i].to, vq[i].st);
            step();
            chk_out($sformatf("vec%0d", i), vq[i].e_state, vq[i].e_io,
                    vq[i].e_rdy, vq[i].e_bsy, vq[i].e_flt);
            inv_en = 1'b1;
        end

        // Brownout, with settle=0 giving a single SETTLE cycle.
        drive(1, 0, 0, 10, 0); step();
        chk_out("bo_rst", 0, 8'h6, 0, 0, 0);
        drive(0, 1, 1, 10, 0);
        step(); chk_out("bo_pu0", 1, 8'h7, 0, 1, 0);
        step(); chk_out("bo_pu1", 1, 8'h7, 0, 1, 0);
        step(); chk_out("bo_settle", 2, 8'h7, 0, 1, 0);
        step(); chk_out("bo_on", 3, 8'h1, 1, 0, 0);
        step(); chk_out("bo_on2", 3, 8'h1, 1, 0, 0);
        pgood = 1'b0;
        step(); chk_out("bo_glitch0", 3, 8'h1, 1, 0, 0);
        pgood = 1'b1;
        step(); chk_out("bo_glitch1", 3, 8'h1, 1, 0, 0);
        step(); chk_out("bo_fault", 6, 8'h6, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(); chk_out($sformatf("bo_hold%0d", i), 6, 8'h6, 0, 0, 1);
        end
        req = 1'b0;
        step(); chk_out("bo_clear", 0, 8'h6, 0, 0, 0);

        // Abort during a long settle: straight to PWRDN, clamps never released.
        drive(1, 0, 0, 10, 100); step();
        drive(0, 1, 1, 10, 100);
        step(); step();
        step(); chk_out("ab_settle", 2, 8'h7, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(); chk($sformatf("ab_noon%0d", i), 32'(state), 32'd2);
        end
        req = 1'b0;
        step(); chk_out("ab_pwrdn", 5, 8'h6, 0, 1, 0);
        pgood = 1'b0;
        begin
            int k;
            k = 0;
            while (state !== 3'd0 && k < 10) begin
                chk($sformatf("ab_clamp%0d", k), 32'(ioring[2:1]), 32'd3);
                step();
                k++;
            end
            chk("ab_off_wait", 32'(k), 32'd3);
        end
        chk_out("ab_off", 0, 8'h6, 0, 0, 0);

        // Reset in the middle of PWRUP.
        drive(0, 1, 0, 10, 3);
        for (int i = 0; i < 3; i++) step();
        chk_out("rp_pwrup", 1, 8'h7, 0, 1, 0);
        reset = 1'b1;
        step(); chk_out("rp_reset", 0, 8'h6, 0, 0, 0);
        reset = 1'b0;
        step(); chk_out("rp_restart", 1, 8'h7, 0, 1, 0);

        inv_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/la_iopwrseq.md
Name: la_iopwrseq

Overview:
- Power sequencer for an io-ring supply segment (vdda/vddio pads and their switchable supply).
- Drives the generic io-ring control word: supply enable, isolation clamp and power-on-reset hold.
- Supervises a power-good feedback from the ring.
- One instance per independently switchable ring segment. Sits between the always-on control logic and the pad ring.

Parameters:
- RINGW, 8, width of io-ring control word (min 3)
- CNTW, 16, width of timeout/settle counters

Ports:
- clk  input  1  sequencer clock
- reset  input  1  synchronous, active-high reset
- req  input  1  1 = segment powered, 0 = segment off
- pgood  input  1  asynchronous power-good from ring supply detector
- timeout_cycles  input  CNTW  max wait for pgood to rise/fall
- settle_cycles  input  CNTW  post-pgood settle time before release
- ioring  output  RINGW  control word: [0]=pwr_en, [1]=iso, [2]=por, [RINGW-1:3]=0
- ready  output  1  segment powered and released
- busy  output  1  transition in progress
- fault  output  1  timeout or brownout latched
- state  output  3  current FSM state code

Behaviour:
- One clock domain. Reset is synchronous and active-high, on clk/reset.
- Reset values:
  - state=OFF(0), ioring=6 (iso=1, por=1, pwr_en=0)
  - ready=0, busy=0, fault=0
  - counter=0, synchronizer flops=0
- Reset asserted mid-sequence forces these values on the next edge, regardless of state.
- pgood passes through a 2-flop synchronizer (pgood_s); 2-cycle latency. All decisions use pgood_s.
- timeout_cycles and settle_cycles are sampled into the counter on state entry only. Changes mid-state are ignored.
- States (code):
  - OFF(0): en=0, iso=1, por=1. req=1 -> PWRUP, cnt<=timeout_cycles.
  - PWRUP(1): en=1, iso=1, por=1, busy=1. Priority:
    - req=0 -> PWRDN, cnt<=timeout_cycles
    - pgood_s=1 -> SETTLE, cnt<=settle_cycles
    - cnt==0 -> FAULT
    - else cnt--
    - Timeout fault occurs after timeout_cycles+1 cycles in PWRUP.
  - SETTLE(2): en=1, iso=1, por=1, busy=1. Priority:
    - req=0 -> PWRDN
    - pgood_s=0 -> FAULT
    - cnt==0 -> ON
    - else cnt--
    - Occupies settle_cycles+1 cycles. settle_cycles=0 -> ON on the next edge.
  - ON(3): en=1, iso=0, por=0, ready=1.
    - pgood_s=0 -> FAULT (brownout, takes priority over req)
    - req=0 -> ISOLATE
  - ISOLATE(4): en=1, iso=1, por=1, busy=1. Exactly one cycle, so clamps close before the supply drops. -> PWRDN, cnt<=timeout_cycles.
  - PWRDN(5): en=0, iso=1, por=1, busy=1. Priority:
    - pgood_s=0 -> OFF
    - cnt==0 -> FAULT
    - else cnt--
    - req is ignored until OFF is reached; no re-arm mid power-down.
  - FAULT(6): en=0, iso=1, por=1, fault=1.
    - Stays while req=1. req=0 -> OFF (fault clears on entry to OFF).
- Outputs are registered, decoded from the state register. ioring bits [RINGW-1:3] are constant 0.
- iso and por are never 0 unless state==ON. A bench assertion enforces this.
- Counter saturates at 0 and never wraps. timeout_cycles=0 gives a single-cycle check.
- ready and busy are never both 1. fault implies ready=0 and busy=0.

Test Plan:
- Reset, then req=1, timeout=10, settle=3, pgood raised 4 cycles after pwr_en:
  - state goes 1 -> 2 -> 3
  - ready rises 2 cycles (sync) + 1 cycle + 4 SETTLE cycles after pgood
  - ioring goes 6 -> 7 -> 1
- Power-down from ON, req=0, pgood drops 3 cycles after pwr_en=0:
  - one ISOLATE cycle with ioring=7
  - PWRDN with ioring=6
  - OFF 2 sync cycles after pgood falls
  - busy deasserts
- Timeout: req=1, timeout=5, pgood held 0:
  - FAULT after exactly 6 PWRUP cycles, fault=1, ioring=6
  - req=0 -> OFF, fault=0
- Brownout: in ON, pulse pgood low for 1 cycle:
  - FAULT 2 cycles later, ioring=6, ready=0
  - remains FAULT until req=0, even though pgood recovers
- Abort: req drops during SETTLE (settle=100):
  - PWRDN next cycle with no ON visit; iso/por never released
- Reset mid-PWRUP, and settle_cycles=0 corner:
  - reset forces state=0, ioring=6 next edge
  - with settle=0, SETTLE lasts exactly 1 cycle
